// File: rtl/friscv_rv32i_control_pkg.sv
// Shared RV32I definitions: opcodes, branch funct3 codes, decoded-bus layout and FSM states.
package friscv_rv32i_control_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_NOP    = 7'b0000000;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Decoded instruction bus layout, LSB first
  localparam int unsigned OPCODE_OFF = 0;
  localparam int unsigned FUNCT3_OFF = 7;
  localparam int unsigned FUNCT7_OFF = 10;
  localparam int unsigned RS1_OFF    = 17;
  localparam int unsigned RS2_OFF    = 22;
  localparam int unsigned RD_OFF     = 27;
  localparam int unsigned ZIMM_OFF   = 32;
  localparam int unsigned IMM12_OFF  = 37;
  localparam int unsigned IMM20_OFF  = 49;
  localparam int unsigned CSR_OFF    = 69;
  localparam int unsigned SHAMT_OFF  = 81;
  localparam int unsigned INST_BUS_W = 86;

  typedef enum logic [0:0] {
    StBoot,
    StFetch
  } ctrl_state_e;

endpackage

// File: rtl/friscv_rv32i_control_decoder.sv
// Combinational RV32I field/immediate extraction, opcode validity and decoded-bus packing.
module friscv_rv32i_control_decoder
  import friscv_rv32i_control_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]       inst,
  output logic [6:0]            opcode,
  output logic [2:0]            funct3,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [4:0]            rd,
  output logic [XLEN-1:0]       imm_i,
  output logic [XLEN-1:0]       imm_u,
  output logic [XLEN-1:0]       imm_j,
  output logic [XLEN-1:0]       imm_b,
  output logic                  inst_error,
  output logic [INST_BUS_W-1:0] instbus
);

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign rd     = inst[11:7];

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));

  always_comb begin
    inst_error = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE,
      OPC_OPIMM, OPC_OP, OPC_SYSTEM, OPC_NOP: inst_error = 1'b0;
      // funct3 010/011 are not branch encodings
      OPC_BRANCH: inst_error = (funct3 == 3'b010) || (funct3 == 3'b011);
      default:    inst_error = 1'b1;
    endcase
  end

  always_comb begin
    instbus = '0;
    instbus[OPCODE_OFF +: 7] = opcode;
    instbus[FUNCT3_OFF +: 3] = funct3;
    instbus[FUNCT7_OFF +: 7] = inst[31:25];
    instbus[RS1_OFF +: 5]    = rs1;
    instbus[RS2_OFF +: 5]    = rs2;
    instbus[RD_OFF +: 5]     = rd;
    instbus[ZIMM_OFF +: 5]   = inst[19:15];
    instbus[IMM12_OFF +: 12] = inst[31:20];
    instbus[IMM20_OFF +: 20] = inst[31:12];
    instbus[CSR_OFF +: 12]   = inst[31:20];
    instbus[SHAMT_OFF +: 5]  = inst[24:20];
  end

endmodule

// File: rtl/friscv_rv32i_control.sv
// RV32I central controller: owns the PC, fetches, executes control flow locally and
// dispatches everything else to the processing unit.
module friscv_rv32i_control
  import friscv_rv32i_control_pkg::*;
#(
  parameter int unsigned ADDRW     = 16,
  parameter int unsigned BOOT_ADDR = 0,
  parameter int unsigned XLEN      = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  output logic                  inst_en,
  output logic [ADDRW-1:0]      inst_addr,
  input  logic [XLEN-1:0]       inst_rdata,
  input  logic                  inst_ready,
  output logic                  proc_en,
  input  logic                  proc_ready,
  input  logic                  proc_empty,
  output logic [INST_BUS_W-1:0] proc_instbus,
  output logic [4:0]            ctrl_rs1_addr,
  input  logic [XLEN-1:0]       ctrl_rs1_val,
  output logic [4:0]            ctrl_rs2_addr,
  input  logic [XLEN-1:0]       ctrl_rs2_val,
  output logic                  ctrl_rd_wr,
  output logic [4:0]            ctrl_rd_addr,
  output logic [XLEN-1:0]       ctrl_rd_val
);

  ctrl_state_e     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_u, imm_j, imm_b;
  logic            inst_error;
  logic [XLEN-1:0] pc_plus4, jalr_target;
  logic            branch_taken;
  logic            unused_aresetn;

  assign unused_aresetn = aresetn;

  friscv_rv32i_control_decoder #(
    .XLEN (XLEN)
  ) u_decoder (
    .inst       (inst_rdata),
    .opcode     (opcode),
    .funct3     (funct3),
    .rs1        (ctrl_rs1_addr),
    .rs2        (ctrl_rs2_addr),
    .rd         (ctrl_rd_addr),
    .imm_i      (imm_i),
    .imm_u      (imm_u),
    .imm_j      (imm_j),
    .imm_b      (imm_b),
    .inst_error (inst_error),
    .instbus    (proc_instbus)
  );

  assign inst_addr   = pc_q[ADDRW-1:0];
  assign pc_plus4    = pc_q + XLEN'(4);
  assign jalr_target = (ctrl_rs1_val + imm_i) & ~XLEN'(1);

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      F3_BEQ:  branch_taken = (ctrl_rs1_val == ctrl_rs2_val);
      F3_BNE:  branch_taken = (ctrl_rs1_val != ctrl_rs2_val);
      F3_BLT:  branch_taken = ($signed(ctrl_rs1_val) < $signed(ctrl_rs2_val));
      F3_BGE:  branch_taken = ($signed(ctrl_rs1_val) >= $signed(ctrl_rs2_val));
      F3_BLTU: branch_taken = (ctrl_rs1_val < ctrl_rs2_val);
      F3_BGEU: branch_taken = (ctrl_rs1_val >= ctrl_rs2_val);
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_en     = 1'b0;
    proc_en     = 1'b0;
    ctrl_rd_wr  = 1'b0;
    ctrl_rd_val = pc_plus4;
    unique case (state_q)
      StBoot: state_d = StFetch;
      StFetch: begin
        inst_en = 1'b1;
        if (inst_ready) begin
          // Invalid encodings retire as NOPs before any opcode-specific handling
          if (inst_error || opcode == OPC_NOP) begin
            pc_d = pc_plus4;
          end else begin
            case (opcode)
              OPC_AUIPC: begin
                ctrl_rd_wr  = 1'b1;
                ctrl_rd_val = pc_q + imm_u;
                pc_d        = pc_plus4;
              end
              OPC_JAL: begin
                ctrl_rd_wr = 1'b1;
                pc_d       = pc_q + imm_j;
              end
              OPC_JALR: begin
                if (proc_empty) begin
                  ctrl_rd_wr = 1'b1;
                  pc_d       = jalr_target;
                end
              end
              OPC_BRANCH: begin
                if (proc_empty) pc_d = branch_taken ? pc_q + imm_b : pc_plus4;
              end
              default: begin
                if (proc_ready) begin
                  proc_en = 1'b1;
                  pc_d    = pc_plus4;
                end
              end
            endcase
          end
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q <= StBoot;
      pc_q    <= XLEN'(BOOT_ADDR);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_friscv_rv32i_control.sv
// Scoreboard bench: each presented instruction pushes its expected response; a monitor
// pops and compares on every cycle the controller sees a valid fetch.
module tb_friscv_rv32i_control;
  import friscv_rv32i_control_pkg::*;

  logic                  aclk = 1'b0;
  logic                  aresetn = 1'b1;
  logic                  srst = 1'b1;
  logic                  inst_en;
  logic [15:0]           inst_addr;
  logic [31:0]           inst_rdata = '0;
  logic                  inst_ready = 1'b0;
  logic                  proc_en;
  logic                  proc_ready = 1'b1;
  logic                  proc_empty = 1'b1;
  logic [INST_BUS_W-1:0] proc_instbus;
  logic [4:0]            ctrl_rs1_addr, ctrl_rs2_addr, ctrl_rd_addr;
  logic [31:0]           ctrl_rs1_val = '0;
  logic [31:0]           ctrl_rs2_val = '0;
  logic                  ctrl_rd_wr;
  logic [31:0]           ctrl_rd_val;

  always #5 aclk = ~aclk;

  friscv_rv32i_control #(
    .ADDRW     (16),
    .BOOT_ADDR (0),
    .XLEN      (32)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .srst          (srst),
    .inst_en       (inst_en),
    .inst_addr     (inst_addr),
    .inst_rdata    (inst_rdata),
    .inst_ready    (inst_ready),
    .proc_en       (proc_en),
    .proc_ready    (proc_ready),
    .proc_empty    (proc_empty),
    .proc_instbus  (proc_instbus),
    .ctrl_rs1_addr (ctrl_rs1_addr),
    .ctrl_rs1_val  (ctrl_rs1_val),
    .ctrl_rs2_addr (ctrl_rs2_addr),
    .ctrl_rs2_val  (ctrl_rs2_val),
    .ctrl_rd_wr    (ctrl_rd_wr),
    .ctrl_rd_addr  (ctrl_rd_addr),
    .ctrl_rd_val   (ctrl_rd_val)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        pen;
    logic        rdwr;
    logic [4:0]  rda;
    logic [31:0] rdv;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one instruction for one cycle and record what the controller must do with it
  task automatic issue(input string name, input logic [31:0] inst, input logic prdy,
                       input logic pemp, input logic [31:0] rs1v, input logic [31:0] rs2v,
                       input logic [31:0] pc, input logic pen, input logic rdwr,
                       input logic [31:0] rdv);
    exp_t e;
    inst_rdata   = inst;
    inst_ready   = 1'b1;
    proc_ready   = prdy;
    proc_empty   = pemp;
    ctrl_rs1_val = rs1v;
    ctrl_rs2_val = rs2v;
    e.name = name; e.pc = pc; e.pen = pen; e.rdwr = rdwr; e.rda = inst[11:7]; e.rdv = rdv;
    expq.push_back(e);
    @(posedge aclk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge aclk);
      if (!srst) begin
        if (inst_en && inst_ready) begin
          if (expq.size() == 0) begin
            chk("unexpected_fetch", 32'(inst_addr), 32'hFFFF_FFFF);
          end else begin
            e = expq.pop_front();
            chk({e.name, ".pc"}, 32'(inst_addr), e.pc);
            chk({e.name, ".proc_en"}, 32'(proc_en), 32'(e.pen));
            chk({e.name, ".rd_wr"}, 32'(ctrl_rd_wr), 32'(e.rdwr));
            if (e.rdwr) begin
              chk({e.name, ".rd_addr"}, 32'(ctrl_rd_addr), 32'(e.rda));
              chk({e.name, ".rd_val"}, ctrl_rd_val, e.rdv);
            end
          end
        end else begin
          chk("idle_strobes", {30'b0, proc_en, ctrl_rd_wr}, 32'b0);
        end
      end
    end
  end

  initial begin : stim
    int wait_cyc;
    repeat (3) @(posedge aclk);
    #1 srst = 1'b0;
    @(negedge aclk);
    chk("boot.inst_en", 32'(inst_en), 32'd0);
    chk("boot.inst_addr", 32'(inst_addr), 32'h0);
    @(posedge aclk);
    #1;
    //      name           inst          prdy  pemp  rs1          rs2          pc     pen  rdwr rdv
    issue("nop",        32'h0000_0000, 1'b1, 1'b1, 32'h0,       32'h0,       32'h00, 1'b0, 1'b0, 32'h0);
    issue("lui",        32'h0000_0037, 1'b1, 1'b1, 32'h0,       32'h0,       32'h04, 1'b1, 1'b0, 32'h0);
    issue("load",       32'h0000_0003, 1'b1, 1'b1, 32'h0,       32'h0,       32'h08, 1'b1, 1'b0, 32'h0);
    issue("store",      32'h0000_0023, 1'b1, 1'b1, 32'h0,       32'h0,       32'h0C, 1'b1, 1'b0, 32'h0);
    issue("opimm",      32'h0000_0013, 1'b1, 1'b1, 32'h0,       32'h0,       32'h10, 1'b1, 1'b0, 32'h0);
    issue("op",         32'h0000_0033, 1'b1, 1'b1, 32'h0,       32'h0,       32'h14, 1'b1, 1'b0, 32'h0);
    issue("system",     32'h0000_0073, 1'b1, 1'b1, 32'h0,       32'h0,       32'h18, 1'b1, 1'b0, 32'h0);
    issue("bad_01",     32'h0000_0001, 1'b1, 1'b1, 32'h0,       32'h0,       32'h1C, 1'b0, 1'b0, 32'h0);
    issue("bad_29",     32'h0000_0029, 1'b1, 1'b1, 32'h0,       32'h0,       32'h20, 1'b0, 1'b0, 32'h0);
    issue("bad_7f",     32'h0000_007F, 1'b1, 1'b1, 32'h0,       32'h0,       32'h24, 1'b0, 1'b0, 32'h0);
    issue("bad_br_f3",  32'h0000_2063, 1'b1, 1'b0, 32'h0,       32'h0,       32'h28, 1'b0, 1'b0, 32'h0);
    issue("auipc",      32'h0000_1197, 1'b1, 1'b1, 32'h0,       32'h0,       32'h2C, 1'b0, 1'b1, 32'h102C);
    issue("jal",        32'h0010_02EF, 1'b1, 1'b1, 32'h0,       32'h0,       32'h30, 1'b0, 1'b1, 32'h34);
    issue("jalr_wait",  32'h0021_00E7, 1'b1, 1'b0, 32'h10,      32'h0,       32'h830, 1'b0, 1'b0, 32'h0);
    issue("jalr",       32'h0021_00E7, 1'b1, 1'b1, 32'h10,      32'h0,       32'h830, 1'b0, 1'b1, 32'h834);
    issue("beq",        32'h0020_8863, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h12, 1'b0, 1'b0, 32'h0);
    issue("blt",        32'h0020_C863, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h00FF_FFFF, 32'h22, 1'b0, 1'b0, 32'h0);
    issue("bltu",       32'h0020_E863, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h00FF_FFFF, 32'h32, 1'b0, 1'b0, 32'h0);
    issue("bgeu",       32'h0020_F863, 1'b1, 1'b1, 32'h00FF_FFF0, 32'h00FF_FFFF, 32'h36, 1'b0, 1'b0, 32'h0);
    issue("bne_wait0",  32'h0020_9863, 1'b1, 1'b0, 32'h1,       32'h2,       32'h3A, 1'b0, 1'b0, 32'h0);
    issue("bne_wait1",  32'h0020_9863, 1'b1, 1'b0, 32'h1,       32'h2,       32'h3A, 1'b0, 1'b0, 32'h0);
    issue("bne",        32'h0020_9863, 1'b1, 1'b1, 32'h1,       32'h2,       32'h3A, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++)
      issue("ld_stall", 32'h0000_2083, 1'b0, 1'b1, 32'h0,       32'h0,       32'h4A, 1'b0, 1'b0, 32'h0);
    issue("ld_go",      32'h0000_2083, 1'b1, 1'b1, 32'h0,       32'h0,       32'h4A, 1'b1, 1'b0, 32'h0);
    issue("nop_tail",   32'h0000_0000, 1'b1, 1'b1, 32'h0,       32'h0,       32'h4E, 1'b0, 1'b0, 32'h0);
    issue("ld_stall2",  32'h0000_2083, 1'b0, 1'b1, 32'h0,       32'h0,       32'h52, 1'b0, 1'b0, 32'h0);
    // Reset lands while the load is still stalled; the instruction is dropped
    srst = 1'b1;
    @(posedge aclk);
    #1;
    srst       = 1'b0;
    inst_ready = 1'b0;
    @(negedge aclk);
    chk("rst.inst_en", 32'(inst_en), 32'd0);
    chk("rst.inst_addr", 32'(inst_addr), 32'h0);
    @(posedge aclk);
    #1;
    issue("resume",     32'h0000_0000, 1'b1, 1'b1, 32'h0,       32'h0,       32'h00, 1'b0, 1'b0, 32'h0);
    issue("resume2",    32'h0000_0013, 1'b1, 1'b1, 32'h0,       32'h0,       32'h04, 1'b1, 1'b0, 32'h0);
    inst_ready = 1'b0;
    wait_cyc = 0;
    while (expq.size() != 0 && wait_cyc < 20) begin
      @(posedge aclk);
      wait_cyc++;
    end
    chk("drain", 32'(expq.size()), 32'd0);
    repeat (2) @(posedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
